johnson_counter_gen: RTL and testbench
======================================

# johnson_counter_gen

Parametrised Johnson (twisted-ring) counter with direction control, enable, synchronous load, legal-state checking with self-correction, a registered state index, a one-hot phase decode and a wrap pulse. It is the general-width successor of the team's fixed 4-bit Johnson counter. It serves as the multi-phase sequencer and clock-phase generator for downstream counter and sequencing blocks. All outputs are registered, and there is one clock domain.

## Interface
Parameters:
- N, default 4: counter width; must be ≥ 2. Sequence length is 2N.
- IDX_W, default $clog2(2N): width of state_idx. Derived; do not override.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- en  in  1  advance one step per clock when high
- dir  in  1  0 = up (forward sequence), 1 = down (reverse)
- load  in  1  synchronous load of load_val
- load_val  in  N  value to load
- q  out  N  Johnson state
- state_idx  out  IDX_W  position of q in the up sequence, 0..2N-1
- phase  out  2N  one-hot decode of state_idx
- tc  out  1  one-cycle wrap pulse
- err  out  1  one-cycle pulse: illegal load value, or illegal q corrected

## Operation
- Up sequence for N=4, indices 0..7: 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, then back to 0000.
- Up step: q_next = {~q[0], q[N-1:1]}.
- Down step: q_next = {q[N-2:0], ~q[N-1]}. This is the exact inverse of the up step.
- Legal state: at most one adjacent-bit transition across q[N-1:0]. There are exactly 2N legal states.
- Index mapping:
  - k ones packed at the MSB end (1..10..0), with 0 ≤ k ≤ N: idx = k.
  - m ones packed at the LSB end (0..01..1), with 1 ≤ m ≤ N-1: idx = 2N-m.
- Priority per edge: rst > load > illegal-q correction > en > hold.
- rst: q=0, state_idx=0, phase=1 (bit 0 set), tc=0, err=0.
- load:
  - Legal load_val: q=load_val, state_idx and phase updated to match, tc=0, err=0.
  - Illegal load_val: q=0, state_idx=0, phase=1, err=1 for one cycle.
  - load overrides en and dir.
- Illegal q while not loading (e.g. an upset): next q=0, state_idx=0, phase=1, err=1. This happens regardless of en.
- en=1: step in the direction given by dir.
  - tc=1 on the following cycle if the step went idx 2N-1 → 0 (up) or 0 → 2N-1 (down).
  - Otherwise tc=0.
- en=0: hold q, state_idx and phase; tc=0, err=0.
- Changing dir between steps is legal. The counter reverses immediately on the next enabled edge.

## Timing
- All outputs are registered. q, state_idx, phase, tc and err update on the same rising edge of clk.
- Latency from en/dir/load to q is one clock. No combinational path exists from any input to any output.
- tc and err are single-cycle pulses. They are never held across consecutive cycles unless the triggering event repeats.
- rst asserted mid-sequence takes effect on the next edge. On that edge all other inputs are ignored.
- load on the same edge as a wrap: load wins and tc=0.
- state_idx and phase are always consistent with q on every cycle.

## Structure
- Package johnson_pkg:
  - function johnson_is_legal(q)
  - function johnson_to_idx(q)
  - function johnson_step(q, dir)
  - Each function is parametrised via width argument or macro N.
- Sub-module johnson_decode, purely combinational: N-bit in → legal flag, IDX_W index, 2N one-hot.
  - Used twice: once on the next-state value (to register state_idx and phase), once on load_val (for the legality check).
- Top module johnson_counter_gen holds the registers, priority muxing and tc/err generation.

## Test plan
- N=4: rst, then en=1, dir=0 for 9 clocks.
  - q steps 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000.
  - state_idx steps 0..7 then 0.
  - phase steps 0x01, 0x02, … 0x80, 0x01.
  - tc=1 only in the cycle q returns to 0000.
- N=4: after rst, dir=1, en=1, 2 clocks.
  - q steps 0001 then 0011; state_idx steps 7 then 6.
  - tc=1 after the first step only.
- N=4: load=1 with load_val=0111 and en=1 on the same edge → q=0111, state_idx=5, tc=0, err=0.
- N=4: load_val=0101 → q=0000 and err=1 for exactly one cycle.
- N=4: force q=1010 → next edge gives q=0000 and err=1, even with en=0.
- N=5: full up cycle of 10 states; tc period is 10.
- N=5: rst asserted mid-count at idx 6 → next cycle q=00000 and state_idx=0.
- N=5: en=0 for 3 clocks → q holds and tc stays 0.

Source files
------------

// File: rtl/johnson_pkg.sv
// ============================================================================
// Module      : johnson_pkg
// Description : Width-generic Johnson counter helpers (legality, index, step).
// Revision    : 1.0
// ============================================================================
`default_nettype none

package johnson_pkg;

   localparam int MAX_N = 32;

   typedef logic [MAX_N-1:0] jvec_t;

   typedef enum logic [1:0] {
      ACT_HOLD = 2'd0,
      ACT_STEP = 2'd1,
      ACT_LOAD = 2'd2,
      ACT_FIX  = 2'd3
   } action_e;

   // Legal Johnson states have at most one adjacent-bit transition.
   function automatic logic johnson_is_legal(input jvec_t q, input int n);
      int trans;
      trans = 0;
      for (int i = 0; i < MAX_N - 1; i++) begin
         if (i < n - 1 && q[i] != q[i+1]) trans++;
      end
      return (trans <= 1);
   endfunction

   // Ones packed at the MSB end give idx = k; ones packed at the LSB end give 2n-m.
   function automatic int johnson_to_idx(input jvec_t q, input int n);
      int ones;
      ones = 0;
      for (int i = 0; i < MAX_N; i++) begin
         if (i < n && q[i]) ones++;
      end
      if (q[n-1] || ones == 0) return ones;
      return 2 * n - ones;
   endfunction

   function automatic jvec_t johnson_step(input jvec_t q, input logic dir, input int n);
      jvec_t r;
      r = '0;
      if (!dir) begin
         for (int i = 0; i < MAX_N - 1; i++) begin
            if (i < n - 1) r[i] = q[i+1];
         end
         r[n-1] = ~q[0];
      end else begin
         for (int i = 1; i < MAX_N; i++) begin
            if (i < n) r[i] = q[i-1];
         end
         r[0] = ~q[n-1];
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/johnson_counter_gen_if.sv
// ============================================================================
// Module      : johnson_counter_gen_if
// Description : Control and status bundle of the Johnson counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface johnson_counter_gen_if #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(2*N)
);
   logic             en;
   logic             dir;
   logic             load;
   logic [N-1:0]     load_val;
   logic [N-1:0]     q;
   logic [IDX_W-1:0] state_idx;
   logic [2*N-1:0]   phase;
   logic             tc;
   logic             err;

   modport master (
      output en, dir, load, load_val,
      input  q, state_idx, phase, tc, err
   );

   modport slave (
      input  en, dir, load, load_val,
      output q, state_idx, phase, tc, err
   );
endinterface

`default_nettype wire

// File: rtl/johnson_decode.sv
// ============================================================================
// Module      : johnson_decode
// Description : Combinational Johnson decode: legal flag, index, one-hot phase.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module johnson_decode
   import johnson_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(2*N)
) (
   input  logic [N-1:0]     i_v,
   output logic             o_legal,
   output logic [IDX_W-1:0] o_idx,
   output logic [2*N-1:0]   o_onehot
);

   always_comb begin
      o_legal  = johnson_is_legal(jvec_t'(i_v), N);
      o_idx    = IDX_W'(johnson_to_idx(jvec_t'(i_v), N));
      o_onehot = (2*N)'(1) << o_idx;
   end

endmodule

`default_nettype wire

// File: rtl/johnson_counter_gen.sv
// ============================================================================
// Module      : johnson_counter_gen
// Description : Parametrised Johnson counter with load, self-correction and decode.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module johnson_counter_gen
   import johnson_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(2*N)
) (
   input  logic                  clk,
   input  logic                  rst,
   johnson_counter_gen_if.slave  bus
);

   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(2*N - 1);

   logic [N-1:0]     r_q;
   logic [IDX_W-1:0] r_idx;
   logic [2*N-1:0]   r_phase;
   logic             r_tc;
   logic             r_err;

   action_e          w_act;
   logic [N-1:0]     w_next;
   logic             w_wrap;
   logic             w_q_legal;
   logic             w_ld_legal;
   logic [IDX_W-1:0] w_ld_idx;
   logic [2*N-1:0]   w_ld_onehot;
   logic             w_nxt_legal;
   logic [IDX_W-1:0] w_nxt_idx;
   logic [2*N-1:0]   w_nxt_phase;
   logic             w_unused;

   johnson_decode #(.N(N), .IDX_W(IDX_W)) u_dec_load (
      .i_v      (bus.load_val),
      .o_legal  (w_ld_legal),
      .o_idx    (w_ld_idx),
      .o_onehot (w_ld_onehot)
   );

   johnson_decode #(.N(N), .IDX_W(IDX_W)) u_dec_next (
      .i_v      (w_next),
      .o_legal  (w_nxt_legal),
      .o_idx    (w_nxt_idx),
      .o_onehot (w_nxt_phase)
   );

   // Only the legality of load_val matters; its index comes back via the next-state decoder.
   assign w_unused = ^{w_ld_idx, w_ld_onehot, w_nxt_legal};

   assign w_q_legal = johnson_is_legal(jvec_t'(r_q), N);
   assign w_wrap    = bus.dir ? (r_idx == '0) : (r_idx == c_last_idx);

   always_comb begin
      w_act  = ACT_HOLD;
      w_next = r_q;
      if (bus.load) begin
         w_act  = w_ld_legal ? ACT_LOAD : ACT_FIX;
         w_next = w_ld_legal ? bus.load_val : '0;
      end else if (!w_q_legal) begin
         w_act  = ACT_FIX;
         w_next = '0;
      end else if (bus.en) begin
         w_act  = ACT_STEP;
         w_next = N'(johnson_step(jvec_t'(r_q), bus.dir, N));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q     <= '0;
         r_idx   <= '0;
         r_phase <= (2*N)'(1);
         r_tc    <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_q     <= w_next;
         r_idx   <= w_nxt_idx;
         r_phase <= w_nxt_phase;
         r_tc    <= (w_act == ACT_STEP) && w_wrap;
         r_err   <= (w_act == ACT_FIX);
      end
   end

   assign bus.q         = r_q;
   assign bus.state_idx = r_idx;
   assign bus.phase     = r_phase;
   assign bus.tc        = r_tc;
   assign bus.err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_johnson_counter_gen.sv
// ============================================================================
// Module      : tb_johnson_counter_gen
// Description : Scoreboard bench for johnson_counter_gen at N=4 and N=5.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_johnson_counter_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst4 = 1'b1;
   logic rst5 = 1'b1;

   johnson_counter_gen_if #(.N(4)) bus4 ();
   johnson_counter_gen_if #(.N(5)) bus5 ();

   johnson_counter_gen #(.N(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4));
   johnson_counter_gen #(.N(5)) dut5 (.clk(clk), .rst(rst5), .bus(bus5));

   typedef struct {
      logic [31:0] q;
      int          idx;
      logic [31:0] phase;
      bit          tc;
      bit          err;
   } exp_t;

   exp_t exp4[$];
   exp_t exp5[$];
   exp_t e4;
   exp_t e5;
   int   n_checks = 0;
   int   n_errors = 0;
   int   m4_idx   = 0;
   int   m5_idx   = 0;

   // Legal state at sequence position k of an n-bit counter.
   function automatic logic [31:0] state_of(input int n, input int k);
      if (k <= n) return ((32'd1 << k) - 32'd1) << (n - k);
      return (32'd1 << (2*n - k)) - 32'd1;
   endfunction

   function automatic int find_idx(input int n, input logic [31:0] v);
      for (int k = 0; k < 2*n; k++) begin
         if (state_of(n, k) == v) return k;
      end
      return -1;
   endfunction

   task automatic model(input int n, inout int idx, input bit r, input bit e, input bit d,
                        input bit l, input logic [31:0] lv, input bit up, output exp_t x);
      int li;
      x.tc  = 1'b0;
      x.err = 1'b0;
      if (r) begin
         idx = 0;
      end else if (l) begin
         li = find_idx(n, lv);
         if (li >= 0) idx = li;
         else begin
            idx   = 0;
            x.err = 1'b1;
         end
      end else if (up) begin
         idx   = 0;
         x.err = 1'b1;
      end else if (e) begin
         if (!d) begin
            x.tc = (idx == 2*n - 1);
            idx  = (idx + 1) % (2*n);
         end else begin
            x.tc = (idx == 0);
            idx  = (idx + 2*n - 1) % (2*n);
         end
      end
      x.q     = state_of(n, idx);
      x.idx   = idx;
      x.phase = 32'd1 << idx;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive4(input bit r, input bit e, input bit d, input bit l,
                         input logic [3:0] lv, input bit up, input logic [3:0] uv);
      exp_t x;
      @(negedge clk);
      rst4          = r;
      bus4.en       = e;
      bus4.dir      = d;
      bus4.load     = l;
      bus4.load_val = lv;
      if (up) begin
         force dut4.r_q = uv;
         #1 release dut4.r_q;
      end
      model(4, m4_idx, r, e, d, l, {28'b0, lv}, up, x);
      exp4.push_back(x);
   endtask

   task automatic drive5(input bit r, input bit e, input bit d, input bit l,
                         input logic [4:0] lv);
      exp_t x;
      @(negedge clk);
      rst5          = r;
      bus5.en       = e;
      bus5.dir      = d;
      bus5.load     = l;
      bus5.load_val = lv;
      model(5, m5_idx, r, e, d, l, {27'b0, lv}, 1'b0, x);
      exp5.push_back(x);
   endtask

   always @(posedge clk) begin
      #1;
      if (exp4.size() > 0) begin
         e4 = exp4.pop_front();
         check("n4_q",     32'(bus4.q),         e4.q);
         check("n4_idx",   32'(bus4.state_idx), 32'(e4.idx));
         check("n4_phase", 32'(bus4.phase),     e4.phase);
         check("n4_tc",    32'(bus4.tc),        32'(e4.tc));
         check("n4_err",   32'(bus4.err),       32'(e4.err));
      end
   end

   always @(posedge clk) begin
      #1;
      if (exp5.size() > 0) begin
         e5 = exp5.pop_front();
         check("n5_q",     32'(bus5.q),         e5.q);
         check("n5_idx",   32'(bus5.state_idx), 32'(e5.idx));
         check("n5_phase", 32'(bus5.phase),     e5.phase);
         check("n5_tc",    32'(bus5.tc),        32'(e5.tc));
         check("n5_err",   32'(bus5.err),       32'(e5.err));
      end
   end

   initial begin
      bus4.en = 1'b0; bus4.dir = 1'b0; bus4.load = 1'b0; bus4.load_val = '0;
      bus5.en = 1'b0; bus5.dir = 1'b0; bus5.load = 1'b0; bus5.load_val = '0;

      // N=4 directed sequence
      drive4(1, 0, 0, 0, 4'b0000, 0, 4'b0000);
      for (int i = 0; i < 9; i++) drive4(0, 1, 0, 0, 4'b0000, 0, 4'b0000);
      drive4(1, 0, 0, 0, 4'b0000, 0, 4'b0000);
      for (int i = 0; i < 2; i++) drive4(0, 1, 1, 0, 4'b0000, 0, 4'b0000);
      drive4(0, 1, 0, 1, 4'b0111, 0, 4'b0000);
      drive4(0, 0, 0, 1, 4'b0101, 0, 4'b0000);
      drive4(0, 0, 0, 0, 4'b0000, 0, 4'b0000);
      drive4(0, 1, 0, 1, 4'b1110, 0, 4'b0000);
      drive4(0, 0, 0, 0, 4'b0000, 1, 4'b1010);
      drive4(0, 0, 0, 0, 4'b0000, 0, 4'b0000);
      drive4(0, 1, 0, 1, 4'b0001, 0, 4'b0000);
      drive4(0, 0, 0, 1, 4'b0011, 0, 4'b0000);

      for (int i = 0; i < 300; i++) begin
         bit r, e, d, l, up;
         logic [3:0] lv, uv;
         r  = ($urandom_range(0, 39) == 0);
         e  = ($urandom_range(0, 9) < 7);
         d  = 1'($urandom_range(0, 1));
         l  = ($urandom_range(0, 9) == 0);
         lv = ($urandom_range(0, 1) == 1) ? 4'(state_of(4, $urandom_range(0, 7))) : 4'($urandom);
         uv = 4'($urandom);
         up = ($urandom_range(0, 19) == 0) && (find_idx(4, {28'b0, uv}) < 0);
         drive4(r, e, d, l, lv, up, uv);
      end
      drive4(1, 0, 0, 0, 4'b0000, 0, 4'b0000);

      // N=5 directed sequence
      drive5(1, 0, 0, 0, 5'b00000);
      for (int i = 0; i < 20; i++) drive5(0, 1, 0, 0, 5'b00000);
      for (int i = 0; i < 6; i++)  drive5(0, 1, 0, 0, 5'b00000);
      drive5(1, 1, 0, 1, 5'b11100);
      for (int i = 0; i < 4; i++)  drive5(0, 1, 0, 0, 5'b00000);
      for (int i = 0; i < 3; i++)  drive5(0, 0, 1, 0, 5'b00000);

      for (int i = 0; i < 300; i++) begin
         bit r, e, d, l;
         logic [4:0] lv;
         r  = ($urandom_range(0, 39) == 0);
         e  = ($urandom_range(0, 9) < 7);
         d  = 1'($urandom_range(0, 1));
         l  = ($urandom_range(0, 9) == 0);
         lv = ($urandom_range(0, 1) == 1) ? 5'(state_of(5, $urandom_range(0, 9))) : 5'($urandom);
         drive5(r, e, d, l, lv);
      end

      @(posedge clk);
      #3;
      check("n4_drain", 32'(exp4.size()), 32'd0);
      check("n5_drain", 32'(exp5.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
